// File: rtl/wb_pkg.sv
// Shared types for the writeback drain: the burst-drain FSM state encoding.
package wb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/fft_beat_serializer.sv
// Splits one wide FFT write into NBEATS valid/ready beats, lowest slice first, one beat per accepted cycle.
// Latency: first beat one cycle after i_start; each beat holds data/addr/last stable until fft_ready.
module fft_beat_serializer
  import wb_pkg::*;
#(
  parameter int INW   = 512,
  parameter int ADDRW = 32,
  parameter int BEATW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [ADDRW-1:0] i_addr,
  input  logic [INW-1:0]   i_data,
  output wb_state_t        o_state,
  output logic             fft_valid,
  input  logic             fft_ready,
  output logic [ADDRW-1:0] fft_addr,
  output logic [BEATW-1:0] fft_data,
  output logic             fft_last
);

  localparam int NBEATS = INW / BEATW;
  localparam int CNTW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  wb_state_t                      r_state;
  wb_state_t                      w_state_nxt;
  logic [CNTW-1:0]                r_beat;
  logic [ADDRW-1:0]               r_base;
  logic [NBEATS-1:0][BEATW-1:0]   r_shadow;
  logic                           w_fire;
  logic                           w_last;

  assign w_fire = (r_state == STREAM) && fft_ready;
  assign w_last = (r_beat == CNTW'(NBEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_beat   <= '0;
      r_base   <= '0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && i_start) begin
        r_shadow <= i_data;
        r_base   <= i_addr;
        r_beat   <= '0;
      end else if (w_fire) begin
        r_beat <= r_beat + CNTW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    fft_valid   = 1'b0;
    fft_addr    = '0;
    fft_data    = '0;
    fft_last    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = STREAM;
      end
      STREAM: begin
        fft_valid = 1'b1;
        fft_addr  = r_base + ADDRW'(r_beat);
        fft_data  = r_shadow[r_beat];
        fft_last  = w_last;
        if (w_fire && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/writeback_drain.sv
// Final writeback consumer: registered rf/cfg/syn strobes (1 cycle) plus FFT burst drain via the serializer.
// Backpressure: stall_out follows registered STREAM state; held instruction is taken in the first IDLE cycle.
module writeback_drain
  import wb_pkg::*;
#(
  parameter int INW   = 512,
  parameter int ADDRW = 32,
  parameter int DATAW = 32,
  parameter int IMMW  = 11,
  parameter int REGW  = 3,
  parameter int BEATW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             fft_wr_en_in,
  input  logic             reg_wr_en_in,
  input  logic             syn_in,
  input  logic             set_en_in,
  input  logic             set_freq_in,
  input  logic [REGW-1:0]  wr_reg_in,
  input  logic [IMMW-1:0]  imm_in,
  input  logic [ADDRW-1:0] addr_in,
  input  logic [INW-1:0]   data_in,
  output logic             stall_out,
  output logic             rf_wr_en,
  output logic [REGW-1:0]  rf_wr_reg,
  output logic [DATAW-1:0] rf_wr_data,
  output logic             cfg_wr_en,
  output logic             cfg_freq_sel,
  output logic [IMMW-1:0]  cfg_imm,
  output logic [DATAW-1:0] cfg_data,
  output logic             syn_pulse,
  output logic             fft_valid,
  input  logic             fft_ready,
  output logic [ADDRW-1:0] fft_addr,
  output logic [BEATW-1:0] fft_data,
  output logic             fft_last
);

  wb_state_t        w_state;
  logic             w_accept;
  logic             r_rf_wr_en;
  logic [REGW-1:0]  r_rf_wr_reg;
  logic [DATAW-1:0] r_rf_wr_data;
  logic             r_cfg_wr_en;
  logic             r_cfg_freq_sel;
  logic [IMMW-1:0]  r_cfg_imm;
  logic [DATAW-1:0] r_cfg_data;
  logic             r_syn_pulse;

  // Inputs are only consumed while idle; during a burst the pipe holds them.
  assign w_accept = valid_in && (w_state == IDLE);

  fft_beat_serializer #(
    .INW   (INW),
    .ADDRW (ADDRW),
    .BEATW (BEATW)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept && fft_wr_en_in),
    .i_addr    (addr_in),
    .i_data    (data_in),
    .o_state   (w_state),
    .fft_valid (fft_valid),
    .fft_ready (fft_ready),
    .fft_addr  (fft_addr),
    .fft_data  (fft_data),
    .fft_last  (fft_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_wr_en     <= 1'b0;
      r_rf_wr_reg    <= '0;
      r_rf_wr_data   <= '0;
      r_cfg_wr_en    <= 1'b0;
      r_cfg_freq_sel <= 1'b0;
      r_cfg_imm      <= '0;
      r_cfg_data     <= '0;
      r_syn_pulse    <= 1'b0;
    end else begin
      r_rf_wr_en  <= w_accept && reg_wr_en_in;
      r_cfg_wr_en <= w_accept && set_en_in;
      r_syn_pulse <= w_accept && syn_in;
      if (w_accept && reg_wr_en_in) begin
        r_rf_wr_reg  <= wr_reg_in;
        r_rf_wr_data <= data_in[DATAW-1:0];
      end
      if (w_accept && set_en_in) begin
        r_cfg_freq_sel <= set_freq_in;
        r_cfg_imm      <= imm_in;
        r_cfg_data     <= data_in[DATAW-1:0];
      end
    end
  end

  assign stall_out    = (w_state == STREAM);
  assign rf_wr_en     = r_rf_wr_en;
  assign rf_wr_reg    = r_rf_wr_reg;
  assign rf_wr_data   = r_rf_wr_data;
  assign cfg_wr_en    = r_cfg_wr_en;
  assign cfg_freq_sel = r_cfg_freq_sel;
  assign cfg_imm      = r_cfg_imm;
  assign cfg_data     = r_cfg_data;
  assign syn_pulse    = r_syn_pulse;

endmodule

// File: tb/tb_writeback_drain.sv
// Directed bench for writeback_drain: strobes, FFT bursts with/without backpressure, wrap and mid-burst reset.
module tb_writeback_drain;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in, fft_wr_en_in, reg_wr_en_in, syn_in, set_en_in, set_freq_in;
  logic [2:0]    wr_reg_in;
  logic [10:0]   imm_in;
  logic [31:0]   addr_in;
  logic [511:0]  data_in;
  logic          stall_out, rf_wr_en, cfg_wr_en, cfg_freq_sel, syn_pulse;
  logic [2:0]    rf_wr_reg;
  logic [31:0]   rf_wr_data, cfg_data;
  logic [10:0]   cfg_imm;
  logic          fft_valid, fft_ready, fft_last;
  logic [31:0]   fft_addr, fft_data;

  int checks = 0;
  int errors = 0;

  writeback_drain dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .fft_wr_en_in(fft_wr_en_in),
    .reg_wr_en_in(reg_wr_en_in), .syn_in(syn_in), .set_en_in(set_en_in),
    .set_freq_in(set_freq_in), .wr_reg_in(wr_reg_in), .imm_in(imm_in),
    .addr_in(addr_in), .data_in(data_in), .stall_out(stall_out),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .cfg_wr_en(cfg_wr_en), .cfg_freq_sel(cfg_freq_sel), .cfg_imm(cfg_imm),
    .cfg_data(cfg_data), .syn_pulse(syn_pulse), .fft_valid(fft_valid),
    .fft_ready(fft_ready), .fft_addr(fft_addr), .fft_data(fft_data), .fft_last(fft_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = 0; fft_wr_en_in = 0; reg_wr_en_in = 0; syn_in = 0;
    set_en_in = 0; set_freq_in = 0; wr_reg_in = '0; imm_in = '0;
    addr_in = '0; data_in = '0;
  endtask

  function automatic logic [511:0] mk_data(input logic [31:0] seed);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = seed + 32'(k);
    return d;
  endfunction

  task automatic test_reset();
    rst_n = 0; fft_ready = 0;
    clear_inputs();
    step(); step();
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    checks++; if (fft_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fft_valid); end
    checks++; if ({rf_wr_en, cfg_wr_en, syn_pulse, fft_last} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {rf_wr_en, cfg_wr_en, syn_pulse, fft_last}); end
    checks++; if ({fft_addr, fft_data, rf_wr_data, cfg_data} !== 128'b0) begin errors++; $display("FAIL reset_data: got %h want 0", {fft_addr, fft_data, rf_wr_data, cfg_data}); end
    rst_n = 1;
    step();
  endtask

  task automatic test_reg_write(input string tag);
    valid_in = 1; reg_wr_en_in = 1; wr_reg_in = 3'd5; data_in = '0; data_in[31:0] = 32'hDEADBEEF;
    step();
    clear_inputs();
    checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL %s_rf_en: got %b want 1", tag, rf_wr_en); end
    checks++; if (rf_wr_reg !== 3'd5) begin errors++; $display("FAIL %s_rf_reg: got %0d want 5", tag, rf_wr_reg); end
    checks++; if (rf_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL %s_rf_data: got %h want deadbeef", tag, rf_wr_data); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL %s_rf_stall: got %b want 0", tag, stall_out); end
    step();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL %s_rf_en_drop: got %b want 0", tag, rf_wr_en); end
  endtask

  // Burst with ready tied high, checking every beat and the stall window length.
  task automatic test_burst(input logic [31:0] base, input string tag);
    logic [31:0] exp_addr;
    fft_ready = 1;
    valid_in = 1; fft_wr_en_in = 1; addr_in = base; data_in = mk_data(32'd1);
    step();
    clear_inputs();
    for (int b = 0; b < 16; b++) begin
      exp_addr = base + 32'(b);
      checks++; if (fft_valid !== 1'b1 || stall_out !== 1'b1) begin errors++; $display("FAIL %s_vld_b%0d: got valid=%b stall=%b want 1/1", tag, b, fft_valid, stall_out); end
      checks++; if (fft_addr !== exp_addr) begin errors++; $display("FAIL %s_addr_b%0d: got %h want %h", tag, b, fft_addr, exp_addr); end
      checks++; if (fft_data !== 32'(b + 1)) begin errors++; $display("FAIL %s_data_b%0d: got %h want %h", tag, b, fft_data, 32'(b + 1)); end
      checks++; if (fft_last !== (b == 15)) begin errors++; $display("FAIL %s_last_b%0d: got %b want %b", tag, b, fft_last, (b == 15)); end
      step();
    end
    checks++; if (stall_out !== 1'b0 || fft_valid !== 1'b0) begin errors++; $display("FAIL %s_end: got stall=%b valid=%b want 0/0", tag, stall_out, fft_valid); end
  endtask

  // Ready pattern 1,0,0 repeating; a held reg write waits behind the burst.
  task automatic test_backpressure();
    int exp_beat = 0;
    int cyc = 0;
    logic done = 0;
    valid_in = 1; fft_wr_en_in = 1; addr_in = 32'h100; data_in = mk_data(32'd1);
    step();
    fft_wr_en_in = 0; reg_wr_en_in = 1; wr_reg_in = 3'd3; data_in = '0; data_in[31:0] = 32'hCAFEF00D;
    while (!done && cyc < 100) begin
      fft_ready = (cyc % 3 == 0);
      checks++; if (fft_valid !== 1'b1 || stall_out !== 1'b1 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL bp_hold_c%0d: got valid=%b stall=%b rf=%b want 1/1/0", cyc, fft_valid, stall_out, rf_wr_en); end
      checks++; if (fft_addr !== 32'h100 + 32'(exp_beat) || fft_data !== 32'(exp_beat + 1)) begin errors++; $display("FAIL bp_beat_c%0d: got addr=%h data=%h want %h/%h", cyc, fft_addr, fft_data, 32'h100 + 32'(exp_beat), 32'(exp_beat + 1)); end
      checks++; if (fft_last !== (exp_beat == 15)) begin errors++; $display("FAIL bp_last_c%0d: got %b want %b", cyc, fft_last, (exp_beat == 15)); end
      step();
      if (fft_ready) begin
        if (exp_beat == 15) done = 1;
        exp_beat++;
      end
      cyc++;
    end
    fft_ready = 0;
    checks++; if (!done) begin errors++; $display("FAIL bp_timeout: got beats=%0d want 16", exp_beat); end
    checks++; if (stall_out !== 1'b0 || fft_valid !== 1'b0 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL bp_idle: got stall=%b valid=%b rf=%b want 0/0/0", stall_out, fft_valid, rf_wr_en); end
    step();
    clear_inputs();
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_reg !== 3'd3 || rf_wr_data !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_held_rf: got en=%b reg=%0d data=%h want 1/3/cafef00d", rf_wr_en, rf_wr_reg, rf_wr_data); end
    step();
  endtask

  task automatic test_combo();
    int cyc = 0;
    valid_in = 1; fft_wr_en_in = 1; reg_wr_en_in = 1; set_en_in = 1; set_freq_in = 1; syn_in = 1;
    wr_reg_in = 3'd6; imm_in = 11'h2A5; addr_in = 32'h40; data_in = mk_data(32'h12345678);
    fft_ready = 0;
    step();
    clear_inputs();
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_reg !== 3'd6 || rf_wr_data !== 32'h12345678) begin errors++; $display("FAIL combo_rf: got en=%b reg=%0d data=%h want 1/6/12345678", rf_wr_en, rf_wr_reg, rf_wr_data); end
    checks++; if (cfg_wr_en !== 1'b1 || cfg_freq_sel !== 1'b1 || cfg_imm !== 11'h2A5 || cfg_data !== 32'h12345678) begin errors++; $display("FAIL combo_cfg: got en=%b sel=%b imm=%h data=%h want 1/1/2a5/12345678", cfg_wr_en, cfg_freq_sel, cfg_imm, cfg_data); end
    checks++; if (syn_pulse !== 1'b1) begin errors++; $display("FAIL combo_syn: got %b want 1", syn_pulse); end
    checks++; if (fft_valid !== 1'b1 || stall_out !== 1'b1 || fft_addr !== 32'h40 || fft_data !== 32'h12345678) begin errors++; $display("FAIL combo_burst: got valid=%b stall=%b addr=%h data=%h want 1/1/40/12345678", fft_valid, stall_out, fft_addr, fft_data); end
    fft_ready = 1;
    step();
    checks++; if ({rf_wr_en, cfg_wr_en, syn_pulse} !== 3'b000) begin errors++; $display("FAIL combo_pulse_drop: got %b want 000", {rf_wr_en, cfg_wr_en, syn_pulse}); end
    checks++; if (fft_addr !== 32'h41 || fft_data !== 32'h12345679) begin errors++; $display("FAIL combo_beat1: got addr=%h data=%h want 41/12345679", fft_addr, fft_data); end
    while (stall_out && cyc < 40) begin step(); cyc++; end
    checks++; if (cyc != 15) begin errors++; $display("FAIL combo_drain: got %0d remaining stall cycles want 15", cyc); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    fft_ready = 1;
    valid_in = 1; fft_wr_en_in = 1; addr_in = 32'h200; data_in = mk_data(32'd1);
    step();
    clear_inputs();
    for (int b = 0; b < 7; b++) step();
    checks++; if (fft_addr !== 32'h207 || fft_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_beat7: got addr=%h valid=%b want 207/1", fft_addr, fft_valid); end
    #1 rst_n = 0;
    #1;
    checks++; if (fft_valid !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL rst_mid_async: got valid=%b stall=%b want 0/0", fft_valid, stall_out); end
    step();
    rst_n = 1;
    for (int c = 0; c < 20; c++) begin
      if (fft_valid || stall_out) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_beats: got %0d active cycles want 0", seen); end
    test_reg_write("post_rst");
  endtask

  initial begin
    test_reset();
    test_reg_write("reg");
    test_burst(32'h100, "burst");
    test_backpressure();
    test_combo();
    test_burst(32'hFFFFFFFC, "wrap");
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_drain.md
Name: writeback_drain

Overview:
- Final-stage consumer of the memory/writeback pipeline register outputs.
- Performs register-file writes, synth config writes and syn pulses, each with one-cycle registered latency.
- Drains 512-bit FFT writes into the FFT sample buffer as a sequence of 32-bit valid/ready beats.
- Asserts stall back to the memory/writeback pipe while a burst is in flight.

Parameters:
- INW, 512, width of the data payload from the pipe
- ADDRW, 32, address width
- DATAW, 32, register-file and config data width
- IMMW, 11, immediate width
- REGW, 3, register index width
- BEATW, 32, FFT buffer beat width; INW must be an integer multiple of BEATW

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_in, fft_wr_en_in, reg_wr_en_in, syn_in, set_en_in, set_freq_in  in  1 each  control bits from the pipe
- wr_reg_in  in  REGW  destination register
- imm_in  in  IMMW  immediate
- addr_in  in  ADDRW  FFT buffer base word address
- data_in  in  INW  payload
- stall_out  out  1  hold request to the memory/writeback pipe
- rf_wr_en  out  1  register-file write strobe
- rf_wr_reg  out  REGW  register-file write index
- rf_wr_data  out  DATAW  register-file write data
- cfg_wr_en  out  1  synth config write strobe
- cfg_freq_sel  out  1  config write targets frequency (1) or other setting (0)
- cfg_imm  out  IMMW  config immediate
- cfg_data  out  DATAW  config data
- syn_pulse  out  1  one-cycle synth trigger
- fft_valid  out  1  beat valid
- fft_ready  in  1  beat accepted by the FFT buffer
- fft_addr  out  ADDRW  beat word address
- fft_data  out  BEATW  beat data
- fft_last  out  1  final beat of the burst

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE and the beat counter is 0.
  - Every output is 0, including stall_out and fft_valid.
  - Reset mid-burst aborts the burst; fft_valid drops asynchronously and the remaining beats are discarded.
- NBEATS = INW/BEATW (16 at the defaults). The beat counter is $clog2(NBEATS) bits wide.
- States are IDLE and STREAM. stall_out = (state==STREAM), decoded from registered state only; there is no combinational path from any input.
- IDLE, each cycle, given valid_in:
  - If reg_wr_en_in: next cycle rf_wr_en=1, rf_wr_reg=wr_reg_in, rf_wr_data=data_in[DATAW-1:0].
  - If set_en_in: next cycle cfg_wr_en=1, cfg_freq_sel=set_freq_in, cfg_imm=imm_in, cfg_data=data_in[DATAW-1:0].
  - If syn_in: next cycle syn_pulse=1.
  - All strobes are single-cycle pulses. Inputs with valid_in=0 are ignored entirely.
  - If fft_wr_en_in: capture data_in and addr_in into a shadow register, clear the beat counter, go to STREAM.
  - Register, config and syn side effects of the same instruction still fire. Any combination of enables on one instruction is legal and all take effect.
- STREAM:
  - All inputs are ignored; the pipe is holding them via stall_out.
  - fft_valid=1, fft_data=shadow[beat*BEATW +: BEATW] (lowest slice first), fft_addr=base+beat, and fft_last=(beat==NBEATS-1).
  - fft_addr wraps modulo 2^ADDRW.
  - A beat transfers on fft_valid&&fft_ready. fft_data, fft_addr and fft_last stay stable while fft_ready=0.
  - A transfer with fft_last=1 returns to IDLE next cycle: fft_valid=0, stall_out=0, and the held instruction is processed in that IDLE cycle.
- Minimum burst is NBEATS cycles; there is no bubble between beats.
- STREAM is the only state in which a stall is issued.

Decomposition:
- Package wb_pkg holds the wb_state_t enum (IDLE, STREAM).
- NBEATS and the counter width are module localparams because they depend on parameters.
- One sub-module, fft_beat_serializer, covers the shadow register, beat counter and valid/ready/last generation.
- writeback_drain instantiates fft_beat_serializer and adds the rf/cfg/syn strobes and stall_out.

Test Plan:
- Reset, then valid_in=1, reg_wr_en_in=1, wr_reg_in=5, data_in[31:0]=0xDEADBEEF -> next cycle rf_wr_en=1, rf_wr_reg=5, rf_wr_data=0xDEADBEEF; the cycle after, rf_wr_en=0.
- FFT write, addr_in=0x100, data slice k=k+1, fft_ready tied 1 -> 16 consecutive beats, addresses 0x100..0x10F, data 1..16, fft_last only on beat 16, stall_out high for exactly 16 cycles.
- Same burst with fft_ready toggled 1,0,0,1,... -> each beat held stable while ready=0, all 16 delivered in order, stall_out stays high until the cycle after the last handshake.
- Single instruction with fft_wr_en_in, reg_wr_en_in, set_en_in, set_freq_in and syn_in all 1 -> rf_wr_en, cfg_wr_en (cfg_freq_sel=1) and syn_pulse pulse once in the next cycle, and the burst starts that same cycle.
- addr_in=0xFFFFFFFC -> addresses 0xFFFFFFFC..0xFFFFFFFF, then 0x0..0xB.
- rst_n pulsed low at beat 7 -> fft_valid and stall_out fall immediately, state IDLE after release, no further beats; then a reg write behaves as in scenario 1.
